// File: rtl/serial_deserializer_if.sv
// Bundle of the serial receive inputs and the valid/ready word output of serial_deserializer.
// slave: deserializer view; master: source/consumer (testbench) view.
interface serial_deserializer_if #(
  parameter int unsigned BW_DATA = 8
);
  logic               i_Sin;
  logic               i_SinVld;
  logic               i_Start;
  logic               i_Rdy;
  logic [BW_DATA-1:0] o_Data;
  logic               o_Vld;
  logic               o_Busy;
  logic               o_Ovf;
  logic               o_ParErr;

  modport slave (
    input  i_Sin, i_SinVld, i_Start, i_Rdy,
    output o_Data, o_Vld, o_Busy, o_Ovf, o_ParErr
  );

  modport master (
    output i_Sin, i_SinVld, i_Start, i_Rdy,
    input  o_Data, o_Vld, o_Busy, o_Ovf, o_ParErr
  );
endinterface

// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver with a one-word valid/ready output buffer.
// Optional macro PARITY_EN: frames carry a trailing even-parity bit reported on o_ParErr.
module serial_deserializer #(
  parameter int unsigned BW_DATA = 8
) (
  input logic                  i_Clk,
  input logic                  i_Rst,
  serial_deserializer_if.slave bus
);

  localparam int unsigned BW_CNT = $clog2(BW_DATA + 2);
`ifdef PARITY_EN
  localparam int unsigned FRAME_LEN = BW_DATA + 1;
`else
  localparam int unsigned FRAME_LEN = BW_DATA;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state, w_state_nxt;
  logic [BW_CNT-1:0]  r_cnt, w_cnt_nxt;
  logic [BW_DATA-1:0] r_sr, w_sr_nxt;
  logic [BW_DATA-1:0] r_data;
  logic               r_vld;
  logic               r_ovf;
  logic               w_done;
  logic               w_accept;

  // Frame assembly: a start bit always opens a fresh frame, discarding any partial one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_SinVld && bus.i_Start) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = BW_CNT'(1);
          w_sr_nxt    = BW_DATA'(bus.i_Sin);
        end
      end
      SHIFT: begin
        if (bus.i_SinVld) begin
          if (bus.i_Start) begin
            w_cnt_nxt = BW_CNT'(1);
            w_sr_nxt  = BW_DATA'(bus.i_Sin);
          end else begin
            w_cnt_nxt = r_cnt + BW_CNT'(1);
            // The parity bit (cnt == BW_DATA) is never shifted into the word.
            if (r_cnt < BW_CNT'(BW_DATA)) begin
              w_sr_nxt = {r_sr[BW_DATA-2:0], bus.i_Sin};
            end
            if (r_cnt == BW_CNT'(FRAME_LEN - 1)) begin
              w_done      = 1'b1;
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_done && (!r_vld || bus.i_Rdy);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      if (w_accept) begin
        r_data <= w_sr_nxt;
        r_vld  <= 1'b1;
      end else if (w_done) begin
        r_ovf  <= 1'b1;
      end else if (r_vld && bus.i_Rdy) begin
        r_vld  <= 1'b0;
      end
    end
  end

`ifdef PARITY_EN
  logic r_par_err;

  // Even parity over data plus parity bit; follows the same accept/drop rule as the word.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_par_err <= 1'b0;
    end else if (w_accept) begin
      r_par_err <= (^w_sr_nxt) ^ bus.i_Sin;
    end
  end

  assign bus.o_ParErr = r_par_err;
`else
  assign bus.o_ParErr = 1'b0;
`endif

  assign bus.o_Data = r_data;
  assign bus.o_Vld  = r_vld;
  assign bus.o_Ovf  = r_ovf;
  assign bus.o_Busy = (r_state == SHIFT);

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-to-parallel receive stage. Consumes the MSB-first bit stream produced by the parallel-load shift register's serial output, possibly after a link.
- Reassembles BW_DATA-bit words and presents each word on a valid/ready output port.
- Includes a one-word output buffer, so the next frame can shift in while the downstream consumer is still holding the previous word.

Parameters:
- BW_DATA, 8, word width in bits; legal range 2..32.

Ports:
- i_Clk  input  1  clock; all logic on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Sin  input  1  serial data bit.
- i_SinVld  input  1  qualifies i_Sin for one cycle; bits are sampled only when high.
- i_Start  input  1  marks the bit with i_SinVld=1 as bit 0 (MSB) of a frame; ignored when i_SinVld=0.
- o_Data  output  BW_DATA  assembled word; first received bit lands in o_Data[BW_DATA-1].
- o_Vld  output  1  o_Data holds an unconsumed word.
- i_Rdy  input  1  consumer accepts o_Data when o_Vld and i_Rdy are both high.
- o_Busy  output  1  high while a frame is partially received.
- o_Ovf  output  1  sticky overflow flag; cleared only by reset.
- o_ParErr  output  1  parity error flag for the word on o_Data.

Behaviour:
- Reset, synchronous, when i_Rst=1 at a clock edge:
  - o_Data=0, o_Vld=0, o_Busy=0, o_Ovf=0, o_ParErr=0.
  - FSM returns to IDLE; bit counter=0; shift register=0.
  - Reset has priority over every other event, including mid-frame; a partial frame is discarded.
- FSM states:
  - IDLE: waits for i_SinVld=1 and i_Start=1. That bit is shifted in, cnt=1, next state SHIFT. Valid bits without i_Start are ignored.
  - SHIFT: each i_SinVld=1 shifts {sr[BW_DATA-2:0], i_Sin} and increments cnt.
    - On the cycle the last bit arrives (cnt reaches BW_DATA, or BW_DATA+1 with the parity bit), the frame completes and the FSM goes to IDLE.
    - i_Start=1 with i_SinVld=1 while in SHIFT: the partial frame is discarded, the bit is taken as bit 0 of a new frame, cnt=1, state stays SHIFT. No error flag is raised.
- o_Busy=1 exactly when the state is SHIFT.
- Counter width: $clog2(BW_DATA+2); no wrap, because the FSM leaves SHIFT at completion.
- Frame completion and output buffer:
  - The completed word moves to o_Data the same edge it completes, i.e. 1 cycle after the last bit is sampled, when the buffer is empty (o_Vld=0) or is being consumed that cycle (o_Vld and i_Rdy both 1).
  - That edge sets o_Vld=1.
  - Total latency: last bit sampled at edge N -> o_Vld=1 visible after edge N.
  - If the buffer is full and not consumed that cycle: the new word is dropped, o_Data is unchanged, and o_Ovf is set to 1.
- Handshake:
  - o_Vld=1 and i_Rdy=1 with no completion that cycle -> o_Vld=0 next cycle; o_Data holds its last value.
  - o_Vld and o_Data stay stable while o_Vld=1 and i_Rdy=0.
  - i_Rdy is ignored while o_Vld=0.
- Back-to-back frames: a start bit may arrive on the cycle right after the last bit of the previous frame, with no idle gap.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the BW_DATA data bits; completion happens on that bit.
  - The parity bit is not stored in o_Data.
  - o_ParErr is loaded with the XOR of the data bits and the parity bit, on the same edge and under the same accept/drop rule as o_Data.
- Undefined:
  - Frames are exactly BW_DATA bits.
  - o_ParErr is tied to 0.

Test Plan (BW_DATA=8):
1. Reset, then i_Rdy=1; send 0xA5 MSB-first with i_SinVld=1 on 8 consecutive cycles and i_Start on the first -> o_Vld=1 with o_Data=0xA5 one edge after bit 7; o_Vld=0 the following cycle; o_Ovf=0.
2. Hold i_Rdy=0; send 0x3C, then 0x81 back-to-back -> o_Data stays 0x3C, o_Ovf=1. Raise i_Rdy -> o_Vld drops; no 0x81 word ever appears.
3. Send 4 bits of 0xFF, then i_Start with the bits of 0x12 -> only 0x12 is delivered; o_Busy stays 1 throughout; o_Ovf=0.
4. Send 0x5A with i_SinVld gaps of 0-3 idle cycles between bits; valid bits without i_Start while IDLE -> ignored. Result: o_Data=0x5A.
5. Assert i_Rst after 5 bits of a frame -> next cycle o_Busy=0, o_Vld=0, o_Data=0. A following full frame of 0xC3 delivers 0xC3.
6. With PARITY_EN defined: send 0xA5 with parity bit 0 -> o_ParErr=0. Send 0xA5 with parity bit 1 -> o_ParErr=1. Without the macro -> o_ParErr is always 0.
